// File: rtl/renderer_pkg.sv
// Shared constants and helpers for the layer compositor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package renderer_pkg;

    // Game status encodings
    localparam logic [1:0] LOAD      = 2'b00;
    localparam logic [1:0] ACTIVATE  = 2'b01;
    localparam logic [1:0] PAUSE     = 2'b10;
    localparam logic [1:0] TERMINATE = 2'b11;

    // Pixels of this colour are see-through
    localparam logic [11:0] KEY_COLOR  = 12'hFFF;
    // Colour shown above and below the background band: B=F, G=8, R=0
    localparam logic [11:0] FILL_COLOR = 12'hF80;

    // Pixel format is {B[11:8], G[7:4], R[3:0]}
    function automatic logic [3:0] chan_r(input logic [11:0] c);
        return c[3:0];
    endfunction

    function automatic logic [3:0] chan_g(input logic [11:0] c);
        return c[7:4];
    endfunction

    function automatic logic [3:0] chan_b(input logic [11:0] c);
        return c[11:8];
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// Per-layer sprite hit test and sprite ROM address generator.
// Latency: 1 clk from pixel coordinate to registered hit and address.
// Backpressure: none, one pixel accepted every clk.
module sprite_hit
    import renderer_pkg::*;
#(
    parameter int SPR_AW = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en_i,
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    input  logic [9:0]        w_i,
    input  logic [9:0]        h_i,
    input  logic [9:0]        px_i,
    input  logic [9:0]        py_i,
    output logic              hit_o,
    output logic [SPR_AW-1:0] addr_o
);

    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic              in_x;
    logic              in_y;
    logic              hit_d;
    logic              hit_q;
    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [SPR_AW-1:0] lin_addr;
    logic [SPR_AW-1:0] addr_d;
    logic [SPR_AW-1:0] addr_q;

    // Right/bottom edges kept at 11 bits so a clipped sprite never wraps to column/row 0
    assign x_end = {1'b0, x_i} + {1'b0, w_i};
    assign y_end = {1'b0, y_i} + {1'b0, h_i};
    assign in_x  = ({1'b0, px_i} >= {1'b0, x_i}) && ({1'b0, px_i} < x_end);
    assign in_y  = ({1'b0, py_i} >= {1'b0, y_i}) && ({1'b0, py_i} < y_end);
    // A zero width or height makes the interval empty, which disables the layer
    assign hit_d = en_i && in_x && in_y;

    // Row-major offset inside the sprite image; only the low SPR_AW bits matter
    assign dx       = px_i - x_i;
    assign dy       = py_i - y_i;
    assign lin_addr = SPR_AW'(dy) * SPR_AW'(w_i) + SPR_AW'(dx);
    assign addr_d   = hit_d ? lin_addr : '0;

    // Register the hit flag and address for the ROM
    always_ff @(posedge clk) begin
        if (clr) begin
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            hit_q  <= hit_d;
            addr_q <= addr_d;
        end
    end

    assign hit_o  = hit_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/layer_compositor.sv
// Composites a scrolling background band with NUM_SPR colour-keyed sprite layers.
// Latency: 3 clk from pixel_x/pixel_y/syncs to red/green/blue/hsync/vsync.
// Backpressure: none, free-running at the pixel clock.
module layer_compositor
    import renderer_pkg::*;
#(
    parameter int          NUM_SPR = 4,
    parameter int          H_ACT   = 640,
    parameter int          V_ACT   = 480,
    parameter int          BG_TOP  = 60,
    parameter int          BG_H    = 360,
    parameter int          BG_AW   = 18,
    parameter int          SPR_AW  = 15,
    parameter logic [11:0] KEY     = KEY_COLOR,
    parameter logic [11:0] FILL    = FILL_COLOR
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [1:0]                status,
    input  logic [3:0]                scroll_step,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      video_on,
    input  logic [9:0]                pixel_x,
    input  logic [9:0]                pixel_y,
    input  logic [NUM_SPR*10-1:0]     spr_x,
    input  logic [NUM_SPR*10-1:0]     spr_y,
    input  logic [NUM_SPR*10-1:0]     spr_w,
    input  logic [NUM_SPR*10-1:0]     spr_h,
    input  logic [NUM_SPR-1:0]        spr_en,
    output logic [BG_AW-1:0]          bg_addr,
    input  logic [11:0]               bg_data,
    output logic [NUM_SPR*SPR_AW-1:0] spr_addr,
    input  logic [NUM_SPR*12-1:0]     spr_data,
    output logic                      hsync,
    output logic                      vsync,
    output logic [3:0]                red,
    output logic [3:0]                green,
    output logic [3:0]                blue
);

    // ---------------- frame boundary, shadow geometry, scroll ----------------
    logic                  at_boundary;
    logic                  boundary_seen_q;
    logic                  frame_tick;
    logic [NUM_SPR*10-1:0] sh_x_q, sh_y_q, sh_w_q, sh_h_q;
    logic [NUM_SPR-1:0]    sh_en_q;
    logic [9:0]            bg_scroll_q;
    logic [9:0]            bg_scroll_d;
    logic [9:0]            scroll_sum;

    assign at_boundary = (pixel_y == 10'(V_ACT)) && (pixel_x == 10'd0);
    // Only the first clk at the boundary position counts, even if the counters stall there
    assign frame_tick  = at_boundary && !boundary_seen_q;
    assign scroll_sum  = bg_scroll_q + 10'(scroll_step);

    // Next scroll offset chosen by game status
    always_comb begin
        bg_scroll_d = bg_scroll_q;
        case (status)
            LOAD:            bg_scroll_d = '0;
            ACTIVATE:        bg_scroll_d = (scroll_sum >= 10'(BG_H)) ? scroll_sum - 10'(BG_H) : scroll_sum;
            PAUSE, TERMINATE: bg_scroll_d = bg_scroll_q;
        endcase
    end

    // Sprite geometry and scroll only change at the frame boundary so a frame never tears
    always_ff @(posedge clk) begin
        if (clr) begin
            boundary_seen_q <= 1'b0;
            sh_x_q          <= '0;
            sh_y_q          <= '0;
            sh_w_q          <= '0;
            sh_h_q          <= '0;
            sh_en_q         <= '0;
            bg_scroll_q     <= '0;
        end else begin
            boundary_seen_q <= at_boundary;
            if (frame_tick) begin
                sh_x_q      <= spr_x;
                sh_y_q      <= spr_y;
                sh_w_q      <= spr_w;
                sh_h_q      <= spr_h;
                sh_en_q     <= spr_en;
                bg_scroll_q <= bg_scroll_d;
            end
        end
    end

    // ---------------- S1: hit test and address calculation ----------------
    logic             in_band;
    logic [9:0]       row_raw;
    logic [9:0]       row;
    logic [BG_AW-1:0] bg_addr_d;
    logic [NUM_SPR-1:0] hit1;

    assign in_band   = (pixel_y >= 10'(BG_TOP)) && (pixel_y < 10'(BG_TOP + BG_H));
    // Offset within the band plus scroll is below 2*BG_H, so one subtraction wraps it
    assign row_raw   = pixel_y - 10'(BG_TOP) + bg_scroll_q;
    assign row       = (row_raw >= 10'(BG_H)) ? row_raw - 10'(BG_H) : row_raw;
    assign bg_addr_d = in_band ? (BG_AW'(row) * BG_AW'(H_ACT) + BG_AW'(pixel_x)) : '0;

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
        sprite_hit #(
            .SPR_AW (SPR_AW)
        ) u_hit (
            .clk    (clk),
            .clr    (clr),
            .en_i   (sh_en_q[i]),
            .x_i    (sh_x_q[10*i +: 10]),
            .y_i    (sh_y_q[10*i +: 10]),
            .w_i    (sh_w_q[10*i +: 10]),
            .h_i    (sh_h_q[10*i +: 10]),
            .px_i   (pixel_x),
            .py_i   (pixel_y),
            .hit_o  (hit1[i]),
            .addr_o (spr_addr[SPR_AW*i +: SPR_AW])
        );
    end

    // ---------------- S1/S2 pipeline registers ----------------
    logic             vld1_q, von1_q, band1_q, hs1_q, vs1_q;
    logic [BG_AW-1:0] bg_addr_q;
    logic             vld2_q, von2_q, band2_q, hs2_q, vs2_q;
    logic [NUM_SPR-1:0] hit2_q;

    // S1 registers the addresses; S2 delays flags to line up with the ROM data
    always_ff @(posedge clk) begin
        if (clr) begin
            vld1_q    <= 1'b0;
            von1_q    <= 1'b0;
            band1_q   <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            bg_addr_q <= '0;
            vld2_q    <= 1'b0;
            von2_q    <= 1'b0;
            band2_q   <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            hit2_q    <= '0;
        end else begin
            vld1_q    <= 1'b1;
            von1_q    <= video_on;
            band1_q   <= in_band;
            hs1_q     <= hsync_in;
            vs1_q     <= vsync_in;
            bg_addr_q <= bg_addr_d;
            vld2_q    <= vld1_q;
            von2_q    <= von1_q;
            band2_q   <= band1_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            hit2_q    <= hit1;
        end
    end

    assign bg_addr = bg_addr_q;

    // ---------------- S3: priority mux ----------------
    logic [11:0] pix_d;

    // Later (higher-index) layers override earlier ones; keyed pixels fall through
    always_comb begin
        pix_d = band2_q ? bg_data : FILL;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (hit2_q[i] && (spr_data[12*i +: 12] != KEY)) begin
                pix_d = spr_data[12*i +: 12];
            end
        end
        if (!von2_q) begin
            pix_d = '0;
        end
    end

    logic [3:0] red_q, green_q, blue_q;
    logic       hs_q, vs_q;

    // Output register; black with inactive syncs until the pipeline has refilled
    always_ff @(posedge clk) begin
        if (clr || !vld2_q) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            red_q   <= chan_r(pix_d);
            green_q <= chan_g(pix_d);
            blue_q  <= chan_b(pix_d);
            hs_q    <= hs2_q;
            vs_q    <= vs2_q;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign hsync = hs_q;
    assign vsync = vs_q;

endmodule
